if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction fetch stage, directly upstream of ID. It owns the fetch PC and issues word reads to the instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO and presented to ID as instruction/PC pairs with a valid/ready handshake. A taken branch or jump from downstream redirects the fetch PC and flushes all in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
PC_STEP, 1, PC increment per instruction (IM is word-addressed)
DEPTH, 2, instruction buffer entries (power of two, at least 2)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
im_req  out  1  read request to instruction memory
im_addr  out  32  read address, held stable while im_req=1
im_ack  in  1  memory returns im_rdata this cycle; completes the request
im_rdata  in  32  instruction word, valid when im_ack=1
br_take  in  1  redirect request from downstream
br_target  in  32  redirect address, valid when br_take=1
id_ready  in  1  ID accepts the head instruction this cycle
if_valid  out  1  if_instruction/if_pc valid
if_instruction  out  32  head instruction, feeds ID im_instruction
if_pc  out  32  address of head instruction
if_npc  out  32  if_pc + PC_STEP, used by ID for link writes (rb_WPC)

Behaviour:
- Reset and decided interface: one clock, CLK; reset port RESET is asynchronous and active-high.
- While RESET=1: state=IDLE, fetch_pc=RESET_PC, buffer empty.
- Reset output values: im_req=0, im_addr=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, if_npc=0.
- FSM states: IDLE, REQ, DISCARD. All state and im_req are registered.
- im_req=1 exactly in REQ and DISCARD. im_addr=fetch_pc in REQ; im_addr=the held old address in DISCARD.
- IDLE:
  - Go to REQ when count_next < DEPTH and br_take=0.
  - On br_take: fetch_pc<=br_target and stay in IDLE; REQ is entered the following cycle.
- REQ:
  - A request completes on an edge where im_req=1 and im_ack=1. Ack in the first cycle of im_req is legal (0-wait memory).
  - On completion without br_take: push {fetch_pc, im_rdata}; fetch_pc<=fetch_pc+PC_STEP (mod 2^32, wrap silently).
  - Then stay in REQ if count_next < DEPTH, else go to IDLE.
  - At most one request is outstanding. A request is only started when a free slot is guaranteed, so a push never overflows.
- Redirect (br_take=1) has priority over every other event in the same cycle:
  - Buffer is flushed (count<=0) and any pop or push that cycle is discarded.
  - fetch_pc<=br_target.
  - In REQ with no ack that cycle: go to DISCARD. im_req stays high with the old address (protocol: no request withdrawal).
  - In REQ with ack that cycle: data is dropped and state goes to REQ at br_target.
- DISCARD:
  - On ack: drop the data and go to REQ with address fetch_pc.
  - A further br_take while in DISCARD only updates fetch_pc.
- FIFO:
  - if_valid = (count != 0); if_instruction/if_pc = head entry; if_npc = head pc + PC_STEP.
  - Pop on if_valid & id_ready & ~br_take. Simultaneous push and pop leaves count unchanged.
  - Outputs hold stable while if_valid=1 and id_ready=0.
  - When empty, the data outputs retain their last values; ID must qualify on if_valid.
- Throughput: with 0-wait memory and id_ready=1, one instruction per cycle.
- First-fetch latency: im_req rises 1 edge after reset release; if_valid rises 1 edge after the ack edge.
- A reset asserted mid-request abandons the request immediately. The memory model must tolerate a dropped request.

Decomposition:
- Shared package (processor-wide defines): FSM state encodings IF_IDLE/IF_REQ/IF_DISCARD, PC width 32, instruction width 32, RESET_PC default value.
- One sub-module, if_fifo: synchronous DEPTH-entry FIFO with flush, push, pop, count and head outputs.
- FSM and PC logic stay in if_stage.

Test Plan:
- Reset then 0-wait memory, id_ready=1 → im_addr sequence 0,1,2,3; if_pc 0,1,2,3 on consecutive cycles; if_npc=if_pc+1.
- id_ready=0 from the start → exactly 2 instructions buffered (pc 0,1), im_req=0 afterwards, outputs stable. Raise id_ready → pc 0,1,2 delivered in order with no gaps or duplicates.
- Memory with 3-cycle ack latency, br_take with br_target=32'h40 issued during the wait → im_addr held at the old value until ack; that data is dropped; next im_addr=32'h40; first if_pc after redirect is 32'h40.
- br_take coincident with im_ack and id_ready → if_valid=0 on the next cycle, buffer flushed, next request at br_target.
- fetch_pc=32'hFFFF_FFFF, then ack → next im_addr=32'h0000_0000 (wrap).
- RESET asserted while im_req=1, mid-wait → im_req, if_valid and state clear immediately without waiting for a clock edge; im_addr=RESET_PC; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Processor-wide fetch definitions shared by the IF stage and its instruction buffer.
package if_stage_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// DEPTH-entry instruction buffer with flush; head is visible combinationally, 1-cycle push-to-head.
// No internal backpressure: the producer only pushes when a free slot is guaranteed.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   flush,
  input  logic                   push,
  input  if_entry_t              push_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output if_entry_t              head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while count != 0.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, reads IM over req/ack, buffers words for ID.
// im_req 1 edge after reset release, if_valid 1 edge after ack; stalls fetch when the buffer would fill.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1,
  parameter int              DEPTH    = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               br_take,
  input  logic [PC_W-1:0]    br_target,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_npc
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if_state_t          state;
  if_state_t          state_next;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    fetch_pc_next;
  logic [PC_W-1:0]    req_addr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               push;
  logic               pop;
  if_entry_t          push_entry;
  if_entry_t          head;
  logic [INSTR_W-1:0] held_instr;
  logic [PC_W-1:0]    held_pc;
  logic [PC_W-1:0]    held_npc;

  assign if_valid   = (count != '0);
  assign push       = (state == IF_REQ) && im_ack && !br_take;
  assign pop        = if_valid && id_ready && !br_take;
  assign count_next = br_take ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign push_entry = '{pc: fetch_pc, instr: im_rdata};

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (br_take),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    unique case (state)
      IF_IDLE: begin
        if (br_take) fetch_pc_next = br_target;
        else if (count_next < DEPTH_CNT) state_next = IF_REQ;
      end
      IF_REQ: begin
        if (br_take) begin
          fetch_pc_next = br_target;
          state_next    = im_ack ? IF_REQ : IF_DISCARD;
        end else if (im_ack) begin
          fetch_pc_next = fetch_pc + PC_STEP;
          state_next    = (count_next < DEPTH_CNT) ? IF_REQ : IF_IDLE;
        end
      end
      IF_DISCARD: begin
        // The memory still owes us the stale word; wait it out before refetching.
        if (br_take) fetch_pc_next = br_target;
        if (im_ack)  state_next    = IF_REQ;
      end
      default: state_next = IF_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IF_IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      im_req     <= 1'b0;
      held_instr <= '0;
      held_pc    <= '0;
      held_npc   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      im_req   <= (state_next != IF_IDLE);
      if (state == IF_REQ) req_addr <= fetch_pc;
      if (if_valid) begin
        held_instr <= head.instr;
        held_pc    <= head.pc;
        held_npc   <= head.pc + PC_STEP;
      end
    end
  end

  // DISCARD keeps presenting the abandoned address until its ack arrives.
  assign im_addr        = (state == IF_DISCARD) ? req_addr : fetch_pc;
  assign if_instruction = if_valid ? head.instr : held_instr;
  assign if_pc          = if_valid ? head.pc : held_pc;
  assign if_npc         = if_valid ? (head.pc + PC_STEP) : held_npc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder with programmable latency, stream model of delivered PCs.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        br_take;
  logic [31:0] br_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_npc;

  int checks  = 0;
  int errors  = 0;
  int mem_lat = 0;

  if_stage dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .br_take        (br_take),
    .br_target      (br_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_npc         (if_npc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Instruction memory: acks after mem_lat waiting cycles, returns instr_of(address).
  initial begin
    int cnt;
    cnt      = 0;
    im_ack   = 1'b0;
    im_rdata = '0;
    forever begin
      @(negedge CLK);
      if (RESET || !im_req) begin
        im_ack = 1'b0;
        cnt    = 0;
      end else if (cnt >= mem_lat) begin
        im_ack   = 1'b1;
        im_rdata = instr_of(im_addr);
        cnt      = 0;
      end else begin
        im_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Stream model: ID must see consecutive PCs from the last reset/redirect, each with its memory word.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;
    logic        prev_wait;
    logic        prev_stall;
    exp_pc     = 32'h0;
    prev_addr  = '0;
    prev_pc    = '0;
    prev_ins   = '0;
    prev_wait  = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      #3;
      if (RESET) begin
        exp_pc     = 32'h0;
        prev_wait  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_wait) begin
          check_b("req_no_withdraw", im_req, 1'b1);
          check("addr_stable", im_addr, prev_addr);
        end
        if (prev_stall) begin
          check_b("stall_valid", if_valid, 1'b1);
          check("stall_pc", if_pc, prev_pc);
          check("stall_ins", if_instruction, prev_ins);
        end
        if (if_valid) begin
          check("stream_pc", if_pc, exp_pc);
          check("stream_ins", if_instruction, instr_of(exp_pc));
          check("stream_npc", if_npc, exp_pc + 32'd1);
          exp_pc = if_pc;
          if (id_ready && !br_take) exp_pc = exp_pc + 32'd1;
        end
        if (br_take) exp_pc = br_target;
        prev_wait  = im_req && !im_ack;
        prev_addr  = im_addr;
        prev_stall = if_valid && !id_ready && !br_take;
        prev_pc    = if_pc;
        prev_ins   = if_instruction;
      end
    end
  end

  task automatic do_reset(input int lat, input logic rdy);
    @(negedge CLK);
    #1;
    RESET     = 1'b1;
    mem_lat   = lat;
    br_take   = 1'b0;
    br_target = '0;
    id_ready  = rdy;
    #1;
    check_b("rst_im_req", im_req, 1'b0);
    check("rst_im_addr", im_addr, 32'h0);
    check_b("rst_if_valid", if_valid, 1'b0);
    check("rst_if_ins", if_instruction, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_npc", if_npc, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #2;
    check_b("rel_im_req", im_req, 1'b0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!if_valid && n < budget) begin
      @(negedge CLK);
      #3;
      n++;
    end
    check_b("wait_valid", if_valid, 1'b1);
  endtask

  initial begin
    RESET     = 1'b1;
    br_take   = 1'b0;
    br_target = '0;
    id_ready  = 1'b0;

    // 0-wait memory, ID always ready: one instruction per cycle.
    do_reset(0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      #3;
      if (k == 1) begin
        check_b("lat_im_req", im_req, 1'b1);
        check_b("lat_if_valid", if_valid, 1'b0);
      end
      if (k <= 4) check("seq_addr", im_addr, 32'(k - 1));
      if (k >= 2) begin
        check_b("seq_valid", if_valid, 1'b1);
        check("seq_pc", if_pc, 32'(k - 2));
      end
      if (k == 2) check("lit_ins0", if_instruction, 32'hDEAD_0000);
      if (k == 3) begin
        check("lit_ins1", if_instruction, 32'hDEAD_0001);
        check("lit_npc1", if_npc, 32'h0000_0002);
      end
    end

    // ID stalled: buffer fills with pc 0,1 and fetch stops.
    do_reset(0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      #3;
      if (k == 2) check("fill_addr", im_addr, 32'h1);
      if (k == 3) check_b("full_no_req", im_req, 1'b0);
      if (k == 5) begin
        check_b("full_no_req2", im_req, 1'b0);
        check_b("full_valid", if_valid, 1'b1);
        check("full_head", if_pc, 32'h0);
      end
    end
    @(negedge CLK);
    id_ready = 1'b1;
    #3;
    check("drain_pc0", if_pc, 32'h0);
    @(negedge CLK);
    #3;
    check("drain_pc1", if_pc, 32'h1);
    check_b("drain_refetch", im_req, 1'b1);
    @(negedge CLK);
    #3;
    check("drain_pc2", if_pc, 32'h2);

    // 3-cycle memory, redirect while waiting: old address held, stale data dropped.
    do_reset(3, 1'b1);
    @(negedge CLK);
    #3;
    check_b("slow_req", im_req, 1'b1);
    check("slow_addr", im_addr, 32'h0);
    @(negedge CLK);
    br_take   = 1'b1;
    br_target = 32'h40;
    #3;
    @(negedge CLK);
    br_take = 1'b0;
    #3;
    check_b("disc_req", im_req, 1'b1);
    check("disc_addr_a", im_addr, 32'h0);
    @(negedge CLK);
    #3;
    check("disc_addr_b", im_addr, 32'h0);
    @(negedge CLK);
    #3;
    check("redir_addr", im_addr, 32'h40);
    check_b("redir_no_valid", if_valid, 1'b0);
    wait_valid(20);
    check("redir_pc", if_pc, 32'h40);
    check("redir_ins", if_instruction, 32'hDEAD_0040);

    // Redirect coincident with ack and pop: everything flushed.
    do_reset(0, 1'b1);
    @(negedge CLK);
    #3;
    @(negedge CLK);
    #3;
    @(negedge CLK);
    br_take   = 1'b1;
    br_target = 32'h100;
    #3;
    check("flush_pre_pc", if_pc, 32'h1);
    @(negedge CLK);
    br_take = 1'b0;
    #3;
    check_b("flush_valid", if_valid, 1'b0);
    check("flush_addr", im_addr, 32'h100);
    @(negedge CLK);
    #3;
    check_b("flush_post_valid", if_valid, 1'b1);
    check("flush_post_pc", if_pc, 32'h100);

    // PC wrap past 32'hFFFF_FFFF.
    do_reset(0, 1'b1);
    @(negedge CLK);
    br_take   = 1'b1;
    br_target = 32'hFFFF_FFFF;
    #3;
    @(negedge CLK);
    br_take = 1'b0;
    #3;
    check("wrap_addr_top", im_addr, 32'hFFFF_FFFF);
    @(negedge CLK);
    #3;
    check("wrap_addr_zero", im_addr, 32'h0);
    check("wrap_pc_top", if_pc, 32'hFFFF_FFFF);
    check("wrap_npc", if_npc, 32'h0);
    @(negedge CLK);
    #3;
    check("wrap_pc_zero", if_pc, 32'h0);

    // Reset mid-request clears without a clock edge, then fetch restarts at RESET_PC.
    do_reset(3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      #3;
    end
    check_b("mid_valid", if_valid, 1'b1);
    check_b("mid_req", im_req, 1'b1);
    check("mid_addr", im_addr, 32'h1);
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check_b("async_req", im_req, 1'b0);
    check_b("async_valid", if_valid, 1'b0);
    check("async_addr", im_addr, 32'h0);
    check("async_pc", if_pc, 32'h0);
    @(negedge CLK);
    #1;
    RESET    = 1'b0;
    id_ready = 1'b1;
    @(negedge CLK);
    #3;
    check_b("restart_req", im_req, 1'b1);
    check("restart_addr", im_addr, 32'h0);
    wait_valid(20);
    check("restart_pc", if_pc, 32'h0);

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
